// File: rtl/dram_lut_rd_valid_monitor_if.sv
// Request/beat strobes and status outputs shared by the DRAM LUT read-valid
// monitor and whatever drives it.
interface dram_lut_rd_valid_monitor_if;
    logic        rd_req;
    logic        rd_valid;
    logic        sw_clear;
    logic [31:0] user_data_in;
    logic        busy;

    modport master (
        output rd_req, rd_valid, sw_clear,
        input  user_data_in, busy
    );

    modport slave (
        input  rd_req, rd_valid, sw_clear,
        output user_data_in, busy
    );
endinterface

// File: rtl/dram_lut_rd_valid_monitor.sv
// Tracks DRAM LUT read requests against returned read-valid beats, measures
// first-beat latency and packs the statistics into the software status word.
module dram_lut_rd_valid_monitor #(
    parameter int BEATS_PER_REQ = 2,
    parameter int FIFO_AW       = 4,
    parameter int TS_W          = 8
) (
    input  logic                       user_clk,
    input  logic                       user_rst,
    dram_lut_rd_valid_monitor_if.slave bus
);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef logic [FIFO_AW:0] occ_t;
    typedef logic [TS_W-1:0]  ts_t;

    localparam occ_t       OCC_FULL   = occ_t'(DEPTH);
    localparam logic [1:0] LAST_PHASE = 2'(BEATS_PER_REQ - 1);

    ts_t                r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    occ_t               r_occ;
    logic [1:0]         r_phase;
    ts_t                r_ts;
    ts_t                r_last_lat;
    ts_t                r_max_lat;
    logic [15:0]        r_beat_cnt;
    logic               r_err_ovf;
    logic               r_err_unf;
    logic [31:0]        r_status;
    logic               r_busy;

    logic        w_has_req;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    ts_t         w_lat;
    occ_t        w_occ_nxt;
    logic [1:0]  w_phase_nxt;
    logic [15:0] w_beat_nxt;
    ts_t         w_last_nxt;
    ts_t         w_max_nxt;
    logic        w_ovf_nxt;
    logic        w_unf_nxt;
    logic [4:0]  w_occ_sat;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_has_req = (r_occ != '0);
        w_full    = (r_occ == OCC_FULL);
        w_lat     = r_ts - r_mem[r_rd_ptr];
        w_pop     = bus.rd_valid && w_has_req && (r_phase == LAST_PHASE);
        // A completing beat frees the head slot before the new request lands.
        w_push    = bus.rd_req && (!w_full || w_pop);

        w_occ_nxt = r_occ;
        if (w_push && !w_pop) begin
            w_occ_nxt = r_occ + occ_t'(1);
        end else if (w_pop && !w_push) begin
            w_occ_nxt = r_occ - occ_t'(1);
        end

        w_phase_nxt = r_phase;
        if (bus.rd_valid && w_has_req) begin
            w_phase_nxt = w_pop ? 2'd0 : r_phase + 2'd1;
        end

        w_beat_nxt = r_beat_cnt;
        w_last_nxt = r_last_lat;
        w_max_nxt  = r_max_lat;
        w_ovf_nxt  = r_err_ovf;
        w_unf_nxt  = r_err_unf;
        if (bus.sw_clear) begin
            w_beat_nxt = '0;
            w_last_nxt = '0;
            w_max_nxt  = '0;
            w_ovf_nxt  = 1'b0;
            w_unf_nxt  = 1'b0;
        end else begin
            if (bus.rd_valid) begin
                w_beat_nxt = r_beat_cnt + 16'd1;
            end
            if (bus.rd_valid && w_has_req && (r_phase == 2'd0)) begin
                w_last_nxt = w_lat;
                w_max_nxt  = (w_lat > r_max_lat) ? w_lat : r_max_lat;
            end
            if (bus.rd_req && w_full && !w_pop) begin
                w_ovf_nxt = 1'b1;
            end
            if (bus.rd_valid && !w_has_req) begin
                w_unf_nxt = 1'b1;
            end
        end

        w_occ_sat = (32'(w_occ_nxt) > 32'd31) ? 5'd31 : 5'(w_occ_nxt);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_ts       <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_phase    <= '0;
            r_beat_cnt <= '0;
            r_last_lat <= '0;
            r_max_lat  <= '0;
            r_err_ovf  <= 1'b0;
            r_err_unf  <= 1'b0;
            r_status   <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_ts <= r_ts + ts_t'(1);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            end
            r_occ      <= w_occ_nxt;
            r_phase    <= w_phase_nxt;
            r_beat_cnt <= w_beat_nxt;
            r_last_lat <= w_last_nxt;
            r_max_lat  <= w_max_nxt;
            r_err_ovf  <= w_ovf_nxt;
            r_err_unf  <= w_unf_nxt;
            r_busy     <= (w_occ_nxt != '0);
            r_status   <= {w_ovf_nxt, w_unf_nxt, w_occ_sat, (w_occ_nxt != '0),
                           8'(w_max_nxt), 8'(w_last_nxt), w_beat_nxt[7:0]};
        end
    end

    // NOTE: the timestamp store has no reset; occupancy gates every read, so stale entries are never used.
    always_ff @(posedge user_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_ts;
        end
    end

    assign bus.user_data_in = r_status;
    assign bus.busy         = r_busy;
endmodule
